// File: rtl/redbus_bus_unit.sv
// CPU-side bus unit: splits 8/16-bit accesses into byte phases and steers each
// byte either to plain memory or to the redbus window, with bus hand-off to an external master.
module redbus_bus_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned WIN_BITS = 8,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic              ReqWide,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [15:0]       ReqWData,
   output logic              RspValid,
   output logic [15:0]       RspRData,
   input  logic [ADDR_W-1:0] CfgBase,
   input  logic              CfgEnable,
   input  logic [7:0]        CfgDevice,
   input  logic [WAIT_W-1:0] CfgWait,
   output logic [ADDR_W-1:0] Address,
   output logic [7:0]        DataOut,
   output logic              DataOe,
   input  logic [7:0]        DataIn,
   output logic              ReadMem,
   output logic              WriteMem,
   output logic              ReadRedbus,
   output logic              WriteRedbus,
   output logic [7:0]        RedbusDevice,
   input  logic              BusRequest,
   output logic              BusRelease
);

   localparam int unsigned CmpW = ADDR_W + 1;

   typedef enum logic [2:0] {IDLE, LSB, MSB, RESP, RELEASED} stateT;

   stateT             state;
   logic              latWrite;
   logic              latWide;
   logic              latEnable;
   logic [ADDR_W-1:0] latAddr;
   logic [ADDR_W-1:0] latBase;
   logic [15:0]       latWData;
   logic [WAIT_W-1:0] latWait;
   logic [WAIT_W-1:0] waitCnt;
   logic [7:0]        lsbByte;

   // Byte about to be driven: LSB comes straight from the request, MSB from the latches.
   logic [ADDR_W-1:0] phAddr;
   logic [ADDR_W-1:0] phBase;
   logic [ADDR_W-1:0] phBusAddr;
   logic              phEn;
   logic              phWrite;
   logic              phMapped;
   logic [7:0]        phByte;
   logic [CmpW-1:0]   winEnd;

   always_comb begin
      if (state == IDLE) begin
         phAddr  = ReqAddr;
         phBase  = CfgBase;
         phEn    = CfgEnable;
         phWrite = ReqWrite;
         phByte  = ReqWData[7:0];
      end else begin
         phAddr  = latAddr + ADDR_W'(1);
         phBase  = latBase;
         phEn    = latEnable;
         phWrite = latWrite;
         phByte  = latWData[15:8];
      end
      // Window end computed one bit wider so it never wraps past the top of memory.
      winEnd    = CmpW'(phBase) + (CmpW'(1) << WIN_BITS);
      phMapped  = phEn && (phAddr >= phBase) && (CmpW'(phAddr) < winEnd);
      phBusAddr = phMapped ? (phAddr - phBase) : phAddr;
   end

   logic lastCycle;
   logic acceptNow;
   logic toMsb;
   logic phaseDone;
   logic loadPhase;
   logic clearPhase;

   assign ReqReady   = (state == IDLE) && !BusRequest;
   assign acceptNow  = ReqValid && ReqReady;
   assign lastCycle  = (waitCnt == '0);
   assign phaseDone  = ((state == LSB) || (state == MSB)) && lastCycle;
   assign toMsb      = (state == LSB) && lastCycle && latWide;
   assign loadPhase  = acceptNow || toMsb;
   assign clearPhase = phaseDone && !toMsb;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         latWrite     <= 1'b0;
         latWide      <= 1'b0;
         latEnable    <= 1'b0;
         latAddr      <= '0;
         latBase      <= '0;
         latWData     <= '0;
         latWait      <= '0;
         waitCnt      <= '0;
         lsbByte      <= '0;
         RspValid     <= 1'b0;
         RspRData     <= '0;
         Address      <= '0;
         DataOut      <= '0;
         DataOe       <= 1'b0;
         ReadMem      <= 1'b0;
         WriteMem     <= 1'b0;
         ReadRedbus   <= 1'b0;
         WriteRedbus  <= 1'b0;
         RedbusDevice <= '0;
         BusRelease   <= 1'b0;
      end else begin
         RspValid <= 1'b0;

         case (state)
            IDLE: begin
               if (BusRequest) begin
                  state      <= RELEASED;
                  BusRelease <= 1'b1;
               end else if (ReqValid) begin
                  latWrite     <= ReqWrite;
                  latWide      <= ReqWide;
                  latAddr      <= ReqAddr;
                  latWData     <= ReqWData;
                  latBase      <= CfgBase;
                  latEnable    <= CfgEnable;
                  latWait      <= CfgWait;
                  RedbusDevice <= CfgDevice;
                  waitCnt      <= CfgWait;
                  state        <= LSB;
               end
            end
            LSB: begin
               if (!lastCycle) begin
                  waitCnt <= waitCnt - WAIT_W'(1);
               end else begin
                  lsbByte <= DataIn;
                  if (latWide) begin
                     waitCnt <= latWait;
                     state   <= MSB;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            MSB: begin
               if (!lastCycle) begin
                  waitCnt <= waitCnt - WAIT_W'(1);
               end else begin
                  state <= RESP;
               end
            end
            RESP: state <= IDLE;
            RELEASED: begin
               if (!BusRequest) begin
                  state      <= IDLE;
                  BusRelease <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Bus pins are set up at each phase start and quieted when the last phase ends.
         if (loadPhase) begin
            Address     <= phBusAddr;
            DataOe      <= phWrite;
            DataOut     <= phWrite ? phByte : 8'h00;
            ReadMem     <= !phWrite && !phMapped;
            WriteMem    <= phWrite && !phMapped;
            ReadRedbus  <= !phWrite && phMapped;
            WriteRedbus <= phWrite && phMapped;
         end else if (clearPhase) begin
            Address     <= '0;
            DataOe      <= 1'b0;
            DataOut     <= 8'h00;
            ReadMem     <= 1'b0;
            WriteMem    <= 1'b0;
            ReadRedbus  <= 1'b0;
            WriteRedbus <= 1'b0;
            RspValid    <= 1'b1;
            if (latWrite) begin
               RspRData <= 16'h0000;
            end else if (state == MSB) begin
               RspRData <= {DataIn, lsbByte};
            end else begin
               RspRData <= {8'h00, DataIn};
            end
         end
      end
   end

endmodule

// File: doc/redbus_bus_unit.md
REDBUS_BUS_UNIT -- requirements
Module: redbus_bus_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address bus width.
REQ-002 SHALL have parameter WIN_BITS, default 8, log2 of redbus window size (256 bytes).
REQ-003 SHALL have parameter WAIT_W, default 4, width of the wait-state count.
REQ-004 Ports SHALL be, one per line: name  direction  width  meaning.
- Clock  in  1  clock
- Reset  in  1  reset, asynchronous, active-high
- ReqValid  in  1  CPU access request
- ReqReady  out  1  request accepted this cycle when ReqValid also high
- ReqWrite  in  1  1 = write, 0 = read
- ReqWide  in  1  1 = 16-bit little-endian access, 0 = 8-bit access
- ReqAddr  in  ADDR_W  byte address
- ReqWData  in  16  write data; low byte only when ReqWide = 0
- RspValid  out  1  one-cycle completion pulse
- RspRData  out  16  read data, valid with RspValid
- CfgBase  in  ADDR_W  redbus window base
- CfgEnable  in  1  redbus mapping enable
- CfgDevice  in  8  redbus device id
- CfgWait  in  WAIT_W  wait states per byte phase
- Address  out  ADDR_W  bus address
- DataOut  out  8  write byte
- DataOe  out  1  DataOut drive enable
- DataIn  in  8  read byte
- ReadMem, WriteMem, ReadRedbus, WriteRedbus  out  1 each  bus strobes
- RedbusDevice  out  8  latched device id
- BusRequest  in  1  external master requests the bus
- BusRelease  out  1  bus handed to the external master

Function
REQ-005 FSM states SHALL be IDLE, LSB, MSB, RESP, RELEASED.
REQ-006 ReqReady SHALL be high only in IDLE with BusRequest low; acceptance = ReqValid & ReqReady.
REQ-007 On acceptance SHALL latch ReqWrite, ReqWide, ReqAddr, ReqWData, CfgBase, CfgEnable, CfgDevice, CfgWait; Cfg changes mid-transaction SHALL have no effect; transition IDLE->LSB.
REQ-008 Each byte phase (LSB, MSB) SHALL last exactly 1+CfgWait cycles, strobe and Address held stable throughout.
REQ-009 Read phases SHALL sample DataIn on the last cycle of the phase; write phases SHALL assert DataOe with DataOut = byte for the whole phase.
REQ-010 Byte address SHALL be ReqAddr for LSB and (ReqAddr+1) mod 2^ADDR_W for MSB.
REQ-011 A byte SHALL be redbus-mapped iff latched CfgEnable = 1 and Base <= addr < Base + 2^WIN_BITS, compared at ADDR_W+1 bits (no wrap; window truncated at top of memory).
REQ-012 Mapped: Read/WriteRedbus strobe, Address = addr - Base zero-extended; unmapped: Read/WriteMem strobe, Address = addr; mapping decided per byte independently.
REQ-013 Exactly one strobe SHALL be high in LSB/MSB; all strobes low in every other state.
REQ-014 LSB->MSB if ReqWide, else LSB->RESP; MSB->RESP.
REQ-015 RESP SHALL last one cycle with RspValid = 1, then ->IDLE; total latency narrow = 2+CfgWait cycles, wide = 3+2*CfgWait cycles from acceptance to RspValid.
REQ-016 RspRData SHALL be {MSB,LSB} for wide reads, {8'h00,LSB} for narrow reads, 16'h0000 for writes; value held until next RESP.
REQ-017 RedbusDevice SHALL output the latched CfgDevice, updated only on acceptance.
REQ-018 BusRequest SHALL be honoured only in IDLE; when BusRequest and ReqValid are both high in IDLE, release wins and the request is not accepted.
REQ-019 IDLE with BusRequest high ->RELEASED next cycle, BusRelease = 1 while in RELEASED.
REQ-020 In RELEASED, Address = 0, DataOe = 0, all strobes = 0, ReqReady = 0.
REQ-021 RELEASED->IDLE the cycle after BusRequest is sampled low; BusRelease then 0.
REQ-022 BusRequest during LSB/MSB/RESP SHALL be ignored until the transaction returns to IDLE.

Reset
REQ-023 Reset SHALL force immediately, asynchronously: state IDLE, BusRelease 0, strobes 0, DataOe 0, Address 0, DataOut 0, RspValid 0, RspRData 0, RedbusDevice 0, all latches 0.
REQ-024 Reset mid-transaction SHALL abort it with no RspValid; first acceptance possible the first cycle after Reset falls.

Verification
REQ-025 Narrow read 0x1234, CfgEnable=0, CfgWait=0, DataIn=0xAB -> ReadMem 1 cycle, Address 0x1234, RspValid 2 cycles after accept, RspRData 0x00AB.
REQ-026 Wide write 0x0300 = 0xBEEF, CfgBase=0x0300, CfgEnable=1, CfgDevice=0x05, CfgWait=2 -> WriteRedbus 3 cycles Address 0x0000 DataOut 0xEF, then 3 cycles Address 0x0001 DataOut 0xBE, RedbusDevice 0x05, RspValid at cycle 7.
REQ-027 Wide read 0x03FF, Base 0x0300 enabled -> LSB ReadRedbus Address 0x00FF, MSB ReadMem Address 0x0400; wide read 0xFFFF -> MSB Address 0x0000.
REQ-028 BusRequest and ReqValid high together in IDLE -> ReqReady 0, BusRelease 1 next cycle, outputs quiet; BusRequest low -> BusRelease 0 next cycle, request then accepted.
REQ-029 Reset asserted during MSB of wide read -> strobes low immediately, no RspValid; next request completes normally.
